alu: RTL and testbench
======================

Name: alu

Overview:
- Parameterised integer ALU for the single-cycle/pipelined MIPS datapath.
- Combinational path: result and zero are produced from a, b and alu_control in the same cycle, for the EX stage and branch compare.
- Registered flag/result stage: captures result and status flags on the clock when enabled, for the pipeline and MCU status register.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 8.
- SHW, $clog2(WIDTH) (derived), number of bits of b used as shift amount.

Ports:
- clk  input  1  system clock; registered stage updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all registered outputs.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt or immediate).
- alu_control  input  4  operation select.
- en  input  1  capture enable for the registered stage.
- result  output  WIDTH  combinational result.
- zero  output  1  combinational; 1 iff result == 0.
- result_q  output  WIDTH  registered result.
- zero_q  output  1  registered zero flag.
- neg_q  output  1  registered result[WIDTH-1].
- ovf_q  output  1  registered signed overflow (ADD/SUB only, else 0).
- carry_q  output  1  registered carry (ADD) / borrow (SUB), else 0.

Behaviour:
- Combinational path has no dependence on clk/rst; outputs settle within the same delta as the inputs.
- Opcodes (shared constants):
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b, modulo 2^WIDTH.
  - 0110 SUB: a - b, modulo 2^WIDTH.
  - 0111 SLT: 1 if $signed(a) < $signed(b), else 0, zero-extended. Must handle mixed signs correctly; do not derive it from the subtraction sign bit alone.
  - 1000 SLTU: unsigned compare, 1/0.
  - 0011 XOR: a ^ b.
  - 1100 NOR: ~(a | b).
  - 0100 SLL: a << b[SHW-1:0].
  - 0101 SRL: a >> b[SHW-1:0], logical.
  - 1001 SRA: $signed(a) >>> b[SHW-1:0].
  - Any other code: result = 0 (hence zero = 1).
- zero = (result == 0) for every opcode, including SLT false and undefined codes.
- Flags (combinational, captured into the registers):
  - ADD overflow: operands have the same sign and the result sign differs.
  - SUB overflow: operands have different signs and the result sign differs from a.
  - ADD carry: bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB carry (borrow): 1 iff a < b unsigned.
  - ovf and carry are 0 for all other opcodes.
- Registered stage:
  - rst high, async: result_q = 0, zero_q = 0, neg_q = 0, ovf_q = 0, carry_q = 0, held while rst is high.
  - Rising clk with en = 1: capture current result, zero, result MSB, ovf, carry. Latency is 1 cycle.
  - en = 0: hold all registered outputs.
  - rst asserted mid-operation clears immediately, regardless of clk/en. First capture happens on the first rising edge after rst deasserts with en = 1.
- Shift amount uses only the low SHW bits of b; upper bits are ignored, so shift 33 behaves as 1 at WIDTH 32.

Decomposition:
- Package alu_pkg: 4-bit opcode localparams (ALU_OP_AND/OR/ADD/SUB/SLT/SLTU/XOR/NOR/SLL/SRL/SRA). Shared with the control/ALU-decoder block.
- One natural sub-module, alu_addsub: a single WIDTH+1-bit adder (b inverted, carry-in 1 for SUB) producing sum, carry and overflow.
- Logic, shifts, compares and the flag register stay in alu.

Test Plan:
- ADD/SUB: a=5, b=10, ADD -> result 15, zero 0. a=100, b=20, SUB -> 80. a=50, b=50, SUB -> 0, zero 1.
- Logic: a=0x0000AAAA, b=0x000000FF. AND -> 0x000000AA. OR -> 0x0000AAFF. NOR -> 0xFFFF5500. XOR -> 0x0000AA55.
- SLT signed:
  - 5 < 10 -> 1, zero 0.
  - 10 < 5 -> 0, zero 1.
  - 0xFFFFFFF6 < 5 -> 1.
  - 0xFFFFFFFB < 0xFFFFFFF6 -> 0, zero 1.
  - SLTU with 0xFFFFFFF6 vs 5 -> 0.
- Shifts: a=0x80000010, b=4. SLL -> 0x00000100. SRL -> 0x08000001. SRA -> 0xF8000001. b=36 gives the same results as b=4.
- Flags/registered:
  - a=0x7FFFFFFF, b=1, ADD, en=1, one edge -> result_q 0x80000000, ovf_q 1, neg_q 1, carry_q 0.
  - a=0xFFFFFFFF, b=1, ADD -> carry_q 1, zero_q 1.
  - en=0 -> registered outputs hold.
- Reset: assert rst between edges with result_q nonzero -> all registered outputs 0 immediately. Undefined opcode 1111 -> result 0, zero 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
//   Opcode encodings for the integer ALU. Shared with the control / ALU-decoder
//   block, so these values must not be renumbered.
package alu_pkg;

    localparam logic [3:0] ALU_OP_AND  = 4'b0000;
    localparam logic [3:0] ALU_OP_OR   = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD  = 4'b0010;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0011;
    localparam logic [3:0] ALU_OP_SLL  = 4'b0100;
    localparam logic [3:0] ALU_OP_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0110;
    localparam logic [3:0] ALU_OP_SLT  = 4'b0111;
    localparam logic [3:0] ALU_OP_SLTU = 4'b1000;
    localparam logic [3:0] ALU_OP_SRA  = 4'b1001;
    localparam logic [3:0] ALU_OP_NOR  = 4'b1100;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub
//   Single WIDTH+1-bit adder shared by ADD and SUB. SUB is a + ~b + 1.
// Ports:
//   a, b   : operands
//   sub    : 1 selects subtraction
//   sum    : a + b or a - b, modulo 2^WIDTH
//   carry  : ADD carry-out, or SUB borrow (1 iff a < b unsigned)
//   ovf    : signed overflow of the selected operation
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   sum_ext;

    assign b_x     = sub ? ~b : b;
    assign sum_ext = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
    assign sum     = sum_ext[WIDTH-1:0];

    // In subtract mode the adder carry-out is "no borrow", so invert it.
    assign carry = sub ? ~sum_ext[WIDTH] : sum_ext[WIDTH];

    // With b already inverted for SUB, one rule covers both cases:
    // same-sign inputs to the adder and a result sign that differs from a.
    assign ovf = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// alu
//   Integer ALU for the MIPS datapath. The combinational result/zero feed the
//   EX stage and branch compare; a registered stage captures result and status
//   flags when en is high.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset of the registered stage
//   a, b         : operands (rs, rt/immediate)
//   alu_control  : opcode, see alu_pkg
//   en           : capture enable for the registered stage
//   result, zero : combinational result and result==0
//   result_q, zero_q, neg_q, ovf_q, carry_q : registered result and flags
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,               // must be >= 8
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    input  logic             en,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q,
    output logic             neg_q,
    output logic             ovf_q,
    output logic             carry_q
);

    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic             is_sub;
    logic [SHW-1:0]   shamt;
    logic             ovf_c;
    logic             carry_c;

    assign is_sub = (alu_control == ALU_OP_SUB);
    // Only the low bits of b select the shift; upper bits are ignored.
    assign shamt  = b[SHW-1:0];

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a     (a),
        .b     (b),
        .sub   (is_sub),
        .sum   (as_sum),
        .carry (as_carry),
        .ovf   (as_ovf)
    );

    always_comb begin
        result  = '0;
        ovf_c   = 1'b0;
        carry_c = 1'b0;
        case (alu_control)
            ALU_OP_AND:  result = a & b;
            ALU_OP_OR:   result = a | b;
            ALU_OP_XOR:  result = a ^ b;
            ALU_OP_NOR:  result = ~(a | b);
            ALU_OP_ADD,
            ALU_OP_SUB: begin
                result  = as_sum;
                ovf_c   = as_ovf;
                carry_c = as_carry;
            end
            // Direct signed compare; the subtraction sign bit alone is wrong
            // when the subtraction overflows.
            ALU_OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_OP_SLL:  result = a << shamt;
            ALU_OP_SRL:  result = a >> shamt;
            ALU_OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            default:     result = '0;
        endcase
    end

    assign zero = (result == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            carry_q  <= 1'b0;
        end else if (en) begin
            result_q <= result;
            zero_q   <= zero;
            neg_q    <= result[WIDTH-1];
            ovf_q    <= ovf_c;
            carry_q  <= carry_c;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu
//   Directed bench for alu at WIDTH 32 with hand-computed expected values.
module tb_alu;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             tb_clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_control;
    logic             en;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;
    logic             carry_q;

    int tests_run = 0;
    int tests_failed = 0;

    alu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (tb_clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .en          (en),
        .result      (result),
        .zero        (zero),
        .result_q    (result_q),
        .zero_q      (zero_q),
        .neg_q       (neg_q),
        .ovf_q       (ovf_q),
        .carry_q     (carry_q)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic comb(input logic [3:0] op, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb);
        alu_control = op;
        a = va;
        b = vb;
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [WIDTH-1:0] r,
                              input logic z, input logic n, input logic o,
                              input logic c);
        check({tag, ".result_q"}, result_q, r);
        check({tag, ".zero_q"},   {31'd0, zero_q},  {31'd0, z});
        check({tag, ".neg_q"},    {31'd0, neg_q},   {31'd0, n});
        check({tag, ".ovf_q"},    {31'd0, ovf_q},   {31'd0, o});
        check({tag, ".carry_q"},  {31'd0, carry_q}, {31'd0, c});
    endtask

    // Capture on one rising edge, then drop en again.
    task automatic capture(input logic [3:0] op, input logic [WIDTH-1:0] va,
                           input logic [WIDTH-1:0] vb);
        @(negedge tb_clk);
        alu_control = op;
        a = va;
        b = vb;
        en = 1'b1;
        @(posedge tb_clk);
        #1;
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0;
        a = '0;
        b = '0;
        alu_control = ALU_OP_AND;
        #2 rst = 1'b1;
        #1;
        check_regs("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge tb_clk);
        rst = 1'b0;

        // Arithmetic
        comb(ALU_OP_ADD, 32'd5, 32'd10);
        check("add_5_10", result, 32'd15);
        check("add_5_10.zero", {31'd0, zero}, 32'd0);
        comb(ALU_OP_SUB, 32'd100, 32'd20);
        check("sub_100_20", result, 32'd80);
        comb(ALU_OP_SUB, 32'd50, 32'd50);
        check("sub_50_50", result, 32'd0);
        check("sub_50_50.zero", {31'd0, zero}, 32'd1);

        // Logic
        comb(ALU_OP_AND, 32'h0000AAAA, 32'h000000FF);
        check("and", result, 32'h000000AA);
        comb(ALU_OP_OR, 32'h0000AAAA, 32'h000000FF);
        check("or", result, 32'h0000AAFF);
        comb(ALU_OP_NOR, 32'h0000AAAA, 32'h000000FF);
        check("nor", result, 32'hFFFF5500);
        comb(ALU_OP_XOR, 32'h0000AAAA, 32'h000000FF);
        check("xor", result, 32'h0000AA55);

        // Compares
        comb(ALU_OP_SLT, 32'd5, 32'd10);
        check("slt_5_10", result, 32'd1);
        check("slt_5_10.zero", {31'd0, zero}, 32'd0);
        comb(ALU_OP_SLT, 32'd10, 32'd5);
        check("slt_10_5", result, 32'd0);
        check("slt_10_5.zero", {31'd0, zero}, 32'd1);
        comb(ALU_OP_SLT, 32'hFFFFFFF6, 32'd5);
        check("slt_neg10_5", result, 32'd1);
        comb(ALU_OP_SLT, 32'hFFFFFFFB, 32'hFFFFFFF6);
        check("slt_neg5_neg10", result, 32'd0);
        check("slt_neg5_neg10.zero", {31'd0, zero}, 32'd1);
        // Sign-overflowing subtraction: 0x7FFFFFFF - 0x80000000 overflows,
        // but 0x7FFFFFFF is the larger signed value.
        comb(ALU_OP_SLT, 32'h80000000, 32'h7FFFFFFF);
        check("slt_min_max", result, 32'd1);
        comb(ALU_OP_SLT, 32'h7FFFFFFF, 32'h80000000);
        check("slt_max_min", result, 32'd0);
        comb(ALU_OP_SLTU, 32'hFFFFFFF6, 32'd5);
        check("sltu_big_5", result, 32'd0);
        comb(ALU_OP_SLTU, 32'd5, 32'hFFFFFFF6);
        check("sltu_5_big", result, 32'd1);

        // Shifts, including shift amount with ignored upper bits
        comb(ALU_OP_SLL, 32'h80000010, 32'd4);
        check("sll_4", result, 32'h00000100);
        comb(ALU_OP_SRL, 32'h80000010, 32'd4);
        check("srl_4", result, 32'h08000001);
        comb(ALU_OP_SRA, 32'h80000010, 32'd4);
        check("sra_4", result, 32'hF8000001);
        comb(ALU_OP_SLL, 32'h80000010, 32'd36);
        check("sll_36", result, 32'h00000100);
        comb(ALU_OP_SRL, 32'h80000010, 32'd36);
        check("srl_36", result, 32'h08000001);
        comb(ALU_OP_SRA, 32'h80000010, 32'd36);
        check("sra_36", result, 32'hF8000001);
        comb(ALU_OP_SRA, 32'h40000010, 32'd4);
        check("sra_pos", result, 32'h04000001);

        // Undefined opcodes
        comb(4'b1111, 32'h12345678, 32'h9ABCDEF0);
        check("undef_1111", result, 32'd0);
        check("undef_1111.zero", {31'd0, zero}, 32'd1);
        comb(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("undef_1010", result, 32'd0);

        // Registered stage stayed cleared while en was low
        check("regs_idle", result_q, 32'd0);

        // Registered flags
        capture(ALU_OP_ADD, 32'h7FFFFFFF, 32'd1);
        check_regs("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0);
        capture(ALU_OP_ADD, 32'hFFFFFFFF, 32'd1);
        check_regs("add_carry", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        capture(ALU_OP_SUB, 32'd5, 32'd10);
        check_regs("sub_borrow", 32'hFFFFFFFB, 1'b0, 1'b1, 1'b0, 1'b1);
        capture(ALU_OP_SUB, 32'h80000000, 32'd1);
        check_regs("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        capture(ALU_OP_SUB, 32'd10, 32'd5);
        check_regs("sub_noborrow", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        capture(ALU_OP_OR, 32'h80000000, 32'h00000001);
        check_regs("or_flags", 32'h80000001, 1'b0, 1'b1, 1'b0, 1'b0);
        capture(ALU_OP_ADD, 32'h7FFFFFFF, 32'd1);

        // en low: new inputs, two edges, registers hold
        @(negedge tb_clk);
        alu_control = ALU_OP_ADD;
        a = 32'hFFFFFFFF;
        b = 32'd1;
        @(posedge tb_clk);
        @(posedge tb_clk);
        #1;
        check_regs("hold", 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset between edges clears at once and holds across an enabled edge
        rst = 1'b1;
        #1;
        check_regs("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        alu_control = ALU_OP_ADD;
        a = 32'd5;
        b = 32'd10;
        @(posedge tb_clk);
        #1;
        check_regs("rst_held", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge tb_clk);
        #1;
        en = 1'b0;
        check_regs("after_rst", 32'd15, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
